// File: rtl/secventiator_retea.sv
// Inference sequencer for the fully-connected digit classifier.
// Clears all stages, then enables them one at a time, moving on when each
// stage raises its done flag. It latches the argmax digit at the end and
// stops with a timeout error if a stage hangs.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one cycle, every stage held in clear
// RUN   | stage k enabled, per-stage watchdog counting
// DONE  | one cycle, gata pulse, result valid
// ERROR | a stage timed out, waiting for start
module secventiator_retea #(
  parameter int NUMAR_STRATURI = 3,
  parameter int LATIME         = 8,
  parameter int TIMEOUT_CICLI  = 4096,
  parameter int LATIME_CONTOR  = 16,
  localparam int LATIME_IDX    = (NUMAR_STRATURI > 1) ? $clog2(NUMAR_STRATURI) : 1,
  localparam int LATIME_WDOG   = (TIMEOUT_CICLI > 2) ? $clog2(TIMEOUT_CICLI) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUMAR_STRATURI-1:0] stare_strat,
  input  logic [LATIME-1:0]         cifra_in,
  output logic [NUMAR_STRATURI-1:0] enable_strat,
  output logic [NUMAR_STRATURI-1:0] reset_strat,
  output logic                      busy,
  output logic                      gata,
  output logic [LATIME-1:0]         cifra_out,
  output logic                      cifra_valida,
  output logic                      eroare_timeout,
  output logic [LATIME_IDX-1:0]     strat_curent,
  output logic [LATIME_CONTOR-1:0]  numar_cicli
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE,
    S_ERROR
  } stare_t;

  localparam logic [LATIME_IDX-1:0]  ULTIM_IDX = LATIME_IDX'(NUMAR_STRATURI - 1);
  localparam logic [LATIME_WDOG-1:0] WDOG_MAX  = LATIME_WDOG'(TIMEOUT_CICLI - 1);

  stare_t                    stare_q, stare_d;
  logic [LATIME_IDX-1:0]     k_q, k_d;
  logic [LATIME_WDOG-1:0]    wdog_q, wdog_d;

  logic [NUMAR_STRATURI-1:0] enable_d, reset_strat_d;
  logic                      busy_d, gata_d, valida_d, eroare_d;
  logic [LATIME-1:0]         cifra_d;
  logic [LATIME_IDX-1:0]     strat_d;
  logic [LATIME_CONTOR-1:0]  cicli_d;

  // Next state, stage index, watchdog and the values every output takes next cycle.
  always_comb begin
    stare_d       = stare_q;
    k_d           = k_q;
    wdog_d        = wdog_q;
    cifra_d       = cifra_out;
    valida_d      = cifra_valida;
    eroare_d      = eroare_timeout;
    cicli_d       = numar_cicli;
    enable_d      = '0;
    reset_strat_d = '0;
    busy_d        = 1'b0;
    gata_d        = 1'b0;
    strat_d       = '0;

    case (stare_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          stare_d  = S_CLEAR;
          valida_d = 1'b0;
          eroare_d = 1'b0;
          cicli_d  = '0;
        end
      end
      S_CLEAR: begin
        stare_d = S_RUN;
        k_d     = '0;
        wdog_d  = '0;
      end
      S_RUN: begin
        if (numar_cicli != '1) cicli_d = numar_cicli + LATIME_CONTOR'(1);
        // A done flag on the watchdog's last cycle still counts as done.
        if (stare_strat[k_q]) begin
          if (k_q == ULTIM_IDX) begin
            cifra_d = cifra_in;
            stare_d = S_DONE;
          end else begin
            k_d    = k_q + LATIME_IDX'(1);
            wdog_d = '0;
          end
        end else if (wdog_q == WDOG_MAX) begin
          stare_d  = S_ERROR;
          eroare_d = 1'b1;
        end else begin
          wdog_d = wdog_q + LATIME_WDOG'(1);
        end
      end
      S_DONE: begin
        stare_d = S_IDLE;
      end
      default: begin
        stare_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (stare_d)
      S_CLEAR: begin
        reset_strat_d = '1;
        busy_d        = 1'b1;
      end
      S_RUN: begin
        enable_d = NUMAR_STRATURI'(1) << k_d;
        busy_d   = 1'b1;
        strat_d  = k_d;
      end
      S_DONE: begin
        gata_d   = 1'b1;
        valida_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State and output registers; reset wins over everything, even mid-run.
  always_ff @(posedge clock) begin
    if (reset) begin
      stare_q        <= S_IDLE;
      k_q            <= '0;
      wdog_q         <= '0;
      enable_strat   <= '0;
      reset_strat    <= '0;
      busy           <= 1'b0;
      gata           <= 1'b0;
      cifra_out      <= '0;
      cifra_valida   <= 1'b0;
      eroare_timeout <= 1'b0;
      strat_curent   <= '0;
      numar_cicli    <= '0;
    end else begin
      stare_q        <= stare_d;
      k_q            <= k_d;
      wdog_q         <= wdog_d;
      enable_strat   <= enable_d;
      reset_strat    <= reset_strat_d;
      busy           <= busy_d;
      gata           <= gata_d;
      cifra_out      <= cifra_d;
      cifra_valida   <= valida_d;
      eroare_timeout <= eroare_d;
      strat_curent   <= strat_d;
      numar_cicli    <= cicli_d;
    end
  end

endmodule

// File: tb/tb_secventiator_retea.sv
// Bench for secventiator_retea: stage models with programmable done latency,
// directed scenarios plus randomized runs checked against a run-level model.
module tb_secventiator_retea;
  localparam int N = 3;
  localparam int W = 8;
  localparam int T = 16;
  localparam int C = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] stare_strat;
  logic [W-1:0] cifra_in;
  logic [N-1:0] enable_strat;
  logic [N-1:0] reset_strat;
  logic         busy;
  logic         gata;
  logic [W-1:0] cifra_out;
  logic         cifra_valida;
  logic         eroare_timeout;
  logic [1:0]   strat_curent;
  logic [C-1:0] numar_cicli;

  int checks = 0;
  int errors = 0;

  int           lat [N];
  int           cnt [N];
  logic [N-1:0] force_m;
  logic [W-1:0] exp_digit;

  secventiator_retea #(
    .NUMAR_STRATURI(N), .LATIME(W), .TIMEOUT_CICLI(T), .LATIME_CONTOR(C)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stare_strat(stare_strat),
    .cifra_in(cifra_in), .enable_strat(enable_strat), .reset_strat(reset_strat),
    .busy(busy), .gata(gata), .cifra_out(cifra_out), .cifra_valida(cifra_valida),
    .eroare_timeout(eroare_timeout), .strat_curent(strat_curent), .numar_cicli(numar_cicli)
  );

  always #5 clock = ~clock;

  // Stage models: count enabled cycles since the last clear, done is sticky once latency reached.
  always @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (reset || reset_strat[i]) cnt[i] <= 0;
      else if (enable_strat[i]) cnt[i] <= cnt[i] + 1;
    end
  end

  // Done flags from the stage models, optionally forced high.
  always_comb begin
    stare_strat = force_m;
    for (int i = 0; i < N; i++)
      if (cnt[i] >= lat[i]) stare_strat[i] = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, 32'(enable_strat), 0);
    chk({tag, "_rs"}, 32'(reset_strat), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_gata"}, 32'(gata), 0);
    chk({tag, "_cifra"}, 32'(cifra_out), 0);
    chk({tag, "_valida"}, 32'(cifra_valida), 0);
    chk({tag, "_err"}, 32'(eroare_timeout), 0);
    chk({tag, "_idx"}, 32'(strat_curent), 0);
    chk({tag, "_cicli"}, 32'(numar_cicli), 0);
  endtask

  // Wait for a run in flight to finish (gata or error), bounded.
  task automatic drain();
    bit fin = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clock);
      if (gata || eroare_timeout) fin = 1;
    end
    chk("drain_bound", 32'(fin), 1);
    if (gata) exp_digit = cifra_in;
    @(negedge clock);
  endtask

  // One inference with stage latencies l0..l2; the model predicts outcome from latencies alone.
  task automatic do_run(input int l0, input int l1, input int l2, input logic [W-1:0] dig,
                        input bit hold);
    int L [N];
    int per_exp [N];
    int per [N];
    int expc, fail_j, prev, bad, seen_g, idx;
    bit fin;
    L[0] = l0; L[1] = l1; L[2] = l2;
    expc = 0; fail_j = -1;
    for (int i = 0; i < N; i++) begin
      int le;
      le = force_m[i] ? 0 : L[i];
      per_exp[i] = 0;
      per[i] = 0;
      if (fail_j < 0) begin
        if (le + 1 <= T) begin per_exp[i] = le + 1; expc += le + 1; end
        else begin per_exp[i] = T; expc += T; fail_j = i; end
      end
    end
    for (int i = 0; i < N; i++) lat[i] = L[i];
    cifra_in = dig;

    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    chk("clear_rs", 32'(reset_strat), 32'h7);
    chk("clear_en", 32'(enable_strat), 0);
    chk("clear_busy", 32'(busy), 1);
    chk("clear_err", 32'(eroare_timeout), 0);
    chk("clear_valida", 32'(cifra_valida), 0);
    chk("clear_cifra", 32'(cifra_out), 32'(exp_digit));
    chk("clear_cicli", 32'(numar_cicli), 0);
    if (!hold) start = 1'b0;

    prev = -1; bad = 0; seen_g = 0; fin = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clock);
      if (gata) seen_g++;
      if (enable_strat != '0) begin
        if (!$onehot(enable_strat)) bad++;
        idx = 0;
        for (int i = 0; i < N; i++) if (enable_strat[i]) idx = i;
        per[idx]++;
        if (32'(strat_curent) != 32'(idx)) bad++;
        if (idx != prev && idx != prev + 1) bad++;
        prev = idx;
      end else if (busy) bad++;
      if (gata || eroare_timeout) fin = 1;
    end
    chk("run_bound", 32'(fin), 1);
    chk("run_order", 32'(bad), 0);
    for (int i = 0; i < N; i++) chk($sformatf("stage%0d_cycles", i), 32'(per[i]), 32'(per_exp[i]));
    chk("cicli", 32'(numar_cicli), 32'(expc));
    chk("busy_end", 32'(busy), 0);
    chk("en_end", 32'(enable_strat), 0);
    if (fail_j < 0) begin
      exp_digit = dig;
      chk("gata_count", 32'(seen_g), 1);
      chk("cifra_out", 32'(cifra_out), 32'(dig));
      chk("valida", 32'(cifra_valida), 1);
      chk("err_ok", 32'(eroare_timeout), 0);
      @(negedge clock);
      chk("gata_pulse", 32'(gata), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("valida_hold", 32'(cifra_valida), 1);
      if (hold) begin
        @(negedge clock);
        chk("restart_busy", 32'(busy), 1);
        chk("restart_rs", 32'(reset_strat), 32'h7);
        start = 1'b0;
        drain();
      end
    end else begin
      chk("err_flag", 32'(eroare_timeout), 1);
      chk("err_gata", 32'(seen_g), 0);
      chk("err_cifra", 32'(cifra_out), 32'(exp_digit));
      chk("err_valida", 32'(cifra_valida), 0);
      chk("err_idx", 32'(strat_curent), 0);
      start = 1'b0;
    end
  endtask

  initial begin
    bit got;
    reset = 1'b1; start = 1'b0; cifra_in = '0; force_m = '0; exp_digit = '0;
    for (int i = 0; i < N; i++) lat[i] = 0;
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Nominal run.
    do_run(3, 4, 11, 8'd7, 0);

    // Stage 1 hangs: timeout, sticky flag, then recovery.
    do_run(3, 100000, 3, 8'd5, 0);
    repeat (4) @(negedge clock);
    chk("err_sticky", 32'(eroare_timeout), 1);
    chk("err_cifra_keep", 32'(cifra_out), 32'd7);
    do_run(2, 5, 1, 8'd6, 0);

    // start held through a whole run.
    do_run(1, 2, 3, 8'd44, 1);

    // Reset in the middle of stage 1.
    lat[0] = 3; lat[1] = 100000; lat[2] = 3; cifra_in = 8'd99;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clock);
      if (enable_strat == 3'b010) got = 1;
    end
    chk("reach_k1", 32'(got), 1);
    reset = 1'b1;
    @(negedge clock);
    chk_all_zero("midreset");
    reset = 1'b0; exp_digit = '0;
    @(negedge clock);
    chk("midreset_idle", 32'(busy), 0);
    do_run(2, 2, 2, 8'd3, 0);

    // Forced stage-2 done ignored during stage 0; done coincides with watchdog expiry.
    force_m = 3'b100;
    do_run(15, 2, 9, 8'd12, 0);
    force_m = '0;
    do_run(16, 2, 2, 8'd13, 0);

    // Back-to-back runs.
    do_run(1, 1, 1, 8'd9, 0);
    do_run(2, 0, 3, 8'd0, 0);

    // Randomized runs.
    for (int r = 0; r < 10; r++)
      do_run($urandom_range(0, 17), $urandom_range(0, 17), $urandom_range(0, 17),
             W'($urandom_range(0, 255)), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "global timeout");
  end
endmodule
